serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It time-multiplexes the team's single one-bit full adder cell, `Full_Adder` (ports `s`, `c`, `a`, `b`, `c0`), to add two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It owns operand capture, a bit counter, carry feedback, result assembly and a start/done handshake. It sits between a requesting controller and the shared full-adder cell.

---
 rtl/serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller driving a shared one-bit full adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module Full_Adder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic c0
);
    assign s = a ^ b ^ c0;
    assign c = (a & b) | (c0 & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next;

    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             fa_s, fa_c;
    logic             load;
    logic             last;

    Full_Adder u_fa (
        .s  (fa_s),
        .c  (fa_c),
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c0 (cy)
    );

    assign last = (cnt == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next-state and operand-load decode
    always_comb begin
        next = state;
        load = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next = RUN;
                    load = 1'b1;
                end
            end
            RUN: begin
                if (last) next = DONE;
            end
            DONE: begin
                if (start) begin
                    next = RUN;
                    load = 1'b1;
                end else begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Operand capture, bit-serial shift and result latch on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            cy   <= c_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh <= {fa_s, s_sh[WIDTH-1:1]};
            cy   <= fa_c;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum   <= {fa_s, s_sh[WIDTH-1:1]};
                c_out <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                // carry into the MSB differs from carry out of it
                ovf   <= cy ^ fa_c;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Define SERIAL_ADD_OVF_EN to also check the ovf output.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run_len = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected results on each done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            prev_done = 1'b0;
        end else begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL overlap busy=%0b done=%0b required not both", busy, done);
            end
            if (busy) run_len++;
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width done high 2 cycles, required 1");
                end
                checks++;
                if (run_len != W) begin
                    errors++;
                    $display("FAIL busy_len got %0d required %0d", run_len, W);
                end
                run_len = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done sum=%h", sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (sum !== e.s || c_out !== e.c) begin
                        errors++;
                        $display("FAIL result got c=%0b sum=%h required c=%0b sum=%h",
                                 c_out, sum, e.c, e.s);
                    end
`ifdef SERIAL_ADD_OVF_EN
                    checks++;
                    if (ovf !== e.o) begin
                        errors++;
                        $display("FAIL ovf got %0b required %0b", ovf, e.o);
                    end
`endif
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL timeout_idle busy=%0b required 0", busy);
        end
    endtask

    task automatic wait_done(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        t = cyc;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout_done done=%0b required 1", done);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        exp_t e;
        wait_idle();
        e.s = es;
        e.c = ec;
        e.o = eo;
        sb.push_back(e);
        a = x;
        b = y;
        c_in = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        c_in = 1'($urandom);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL %s busy=%0b done=%0b sum=%h c_out=%0b required all 0",
                     tag, busy, done, sum, c_out);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf got %0b required 0", tag, ovf);
        end
`endif
    endtask

    int t0, t1, t2;

    initial begin
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // start and operand changes mid-run are ignored
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        c_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // back-to-back with start held high
        wait_idle();
        a = 8'h01;
        b = 8'h02;
        c_in = 1'b0;
        repeat (3) sb.push_back('{8'h03, 1'b0, 1'b0});
        start = 1'b1;
        @(negedge clk);
        wait_done(t0);
        wait_done(t1);
        @(negedge clk);
        start = 1'b0;
        wait_done(t2);
        checks++;
        if (t1 - t0 != W + 1) begin
            errors++;
            $display("FAIL b2b_gap1 got %0d required %0d", t1 - t0, W + 1);
        end
        checks++;
        if (t2 - t1 != W + 1) begin
            errors++;
            $display("FAIL b2b_gap2 got %0d required %0d", t2 - t1, W + 1);
        end

        // reset four cycles into a run
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sum !== 8'h03) begin
            errors++;
            $display("FAIL pre_reset busy=%0b sum=%h required 1 03", busy, sum);
        end
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_zero("post_reset");

        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending got %0d results left required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
